// File: rtl/pstack.sv
// pstack: predicate (active-lane mask) stack for the SIMT scheduler.
//
// Each nesting level of divergent control flow holds one lane-enable mask.
// Level 0 is a hardwired all-ones base entry; DEPTH further levels can be
// pushed. The mask at the current level is driven on q and gates which
// cores execute.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  asynchronous active-low reset; clears the whole stack
//   d      predicate mask to push (ANDed with the enclosing level)
//   q      current top-of-stack mask
//   push   push request
//   pop    pop request (highest priority)
//   comp   complement-top request for the else-path (lowest priority)
module pstack #(
    parameter int N_CORES = 4,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CORES-1:0] d,
    output logic [N_CORES-1:0] q,
    input  logic               push,
    input  logic               pop,
    input  logic               comp
);

    localparam int PTR_W = $clog2(DEPTH + 1);

    // stk[i] holds level i+1; level 0 is the implicit all-ones base.
    logic [N_CORES-1:0] stk [DEPTH];
    logic [PTR_W-1:0]   lvl;
    logic [PTR_W-1:0]   lvl_up;
    logic [N_CORES-1:0] below;
    logic               do_pop;
    logic               do_push;
    logic               do_comp;

    assign lvl_up = lvl + PTR_W'(1);

    // One operation per cycle: pop > push > comp, each ignored at its limit.
    assign do_pop  = pop && (lvl != '0);
    assign do_push = !pop && push && (lvl != PTR_W'(DEPTH));
    assign do_comp = !pop && !push && comp && (lvl != '0);

    // q and the mask one level below the top are muxed from registers only,
    // so there is no combinational path from d to q.
    always_comb begin
        q     = '1;
        below = '1;
        for (int i = 0; i < DEPTH; i++) begin
            if (lvl == PTR_W'(i + 1)) q = stk[i];
            if (lvl == PTR_W'(i + 2)) below = stk[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvl <= '0;
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
        end else begin
            if (do_pop)  lvl <= lvl - PTR_W'(1);
            if (do_push) lvl <= lvl_up;
            for (int i = 0; i < DEPTH; i++) begin
                // Nested masks can only narrow the enclosing level's lanes.
                if (do_push && lvl_up == PTR_W'(i + 1)) stk[i] <= d & q;
                // Masking with the level below makes comp self-inverse.
                if (do_comp && lvl == PTR_W'(i + 1)) stk[i] <= ~q & below;
            end
        end
    end

endmodule

// File: tb/tb_pstack.sv
module tb_pstack;

    localparam int N     = 4;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic         push;
    logic         pop;
    logic         comp;

    int passed = 0;
    int total  = 0;

    // Reference: the stack as a queue of masks; empty queue means base level.
    logic [N-1:0] ref_stk [$];

    pstack #(.N_CORES(N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q),
        .push  (push),
        .pop   (pop),
        .comp  (comp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        if (obs !== exp)
            $display("FAIL %s: q=%b expected %b at %0t", tag, obs, exp, $time);
        else
            passed++;
    endtask

    function automatic logic [N-1:0] ref_top();
        if (ref_stk.size() == 0) return '1;
        return ref_stk[$];
    endfunction

    function automatic logic [N-1:0] ref_below();
        if (ref_stk.size() < 2) return '1;
        return ref_stk[ref_stk.size() - 2];
    endfunction

    function automatic void ref_apply(input bit pu, input bit po, input bit co, input logic [N-1:0] dv);
        logic [N-1:0] t;
        if (po) begin
            if (ref_stk.size() > 0) void'(ref_stk.pop_back());
        end else if (pu) begin
            if (ref_stk.size() < DEPTH) ref_stk.push_back(dv & ref_top());
        end else if (co) begin
            if (ref_stk.size() > 0) begin
                t = ~ref_top() & ref_below();
                ref_stk[ref_stk.size() - 1] = t;
            end
        end
    endfunction

    // Drive one cycle of requests, then check q just after the sampling edge.
    task automatic op(input bit pu, input bit po, input bit co, input logic [N-1:0] dv,
                      input string tag, input logic [N-1:0] exp);
        @(negedge clk);
        push = pu; pop = po; comp = co; d = dv;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; comp = 1'b0;
        ref_apply(pu, po, co, dv);
        chk(tag, q, exp);
        chk({tag, "_ref"}, q, ref_top());
    endtask

    initial begin
        reset = 1'b0; push = 1'b0; pop = 1'b0; comp = 1'b0; d = '0;
        #1;
        chk("reset_assert", q, 4'b1111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_release", q, 4'b1111);

        op(0, 1, 0, 4'b0000, "pop_empty0", 4'b1111);

        op(1, 0, 0, 4'b1010, "push1", 4'b1010);
        op(1, 0, 0, 4'b0011, "push2", 4'b0010);
        op(1, 0, 0, 4'b0111, "push3", 4'b0010);

        op(0, 0, 1, 4'b0000, "comp1", 4'b0000);
        op(0, 0, 1, 4'b0000, "comp2", 4'b0010);

        op(0, 1, 0, 4'b0000, "pop1", 4'b0010);
        op(0, 1, 0, 4'b0000, "pop2", 4'b1010);
        op(0, 1, 0, 4'b0000, "pop3", 4'b1111);
        op(0, 1, 0, 4'b0000, "pop_empty", 4'b1111);

        for (int i = 0; i < DEPTH; i++) op(1, 0, 0, 4'b1111, "push_fill", 4'b1111);
        op(1, 0, 0, 4'b0000, "push_full", 4'b1111);
        for (int i = 0; i < DEPTH; i++) op(0, 1, 0, 4'b0000, "pop_drain", 4'b1111);

        op(1, 0, 0, 4'b1010, "push_lvl1", 4'b1010);
        op(1, 1, 0, 4'b0101, "pop_over_push", 4'b1111);
        op(0, 0, 1, 4'b0000, "comp_lvl0", 4'b1111);

        // Async reset in the middle of a three-deep stack.
        op(1, 0, 0, 4'b1110, "pre_rst1", 4'b1110);
        op(1, 0, 0, 4'b0111, "pre_rst2", 4'b0110);
        op(1, 0, 0, 4'b0101, "pre_rst3", 4'b0100);
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset", q, 4'b1111);
        ref_stk.delete();
        @(negedge clk);
        reset = 1'b1;
        op(0, 1, 0, 4'b0000, "pop_after_rst", 4'b1111);

        // Randomized ops, biased so the stack reaches both empty and full.
        for (int i = 0; i < 400; i++) begin
            bit pu, po, co;
            logic [N-1:0] dv;
            int r;
            r  = $urandom_range(0, 99);
            pu = (r < 45) || (r >= 90 && r < 95);
            po = (r >= 45 && r < 70) || (r >= 90);
            co = (r >= 70 && r < 90) || (r >= 93);
            dv = N'($urandom);
            @(negedge clk);
            push = pu; pop = po; comp = co; d = dv;
            @(posedge clk);
            #1;
            push = 1'b0; pop = 1'b0; comp = 1'b0;
            ref_apply(pu, po, co, dv);
            chk("random", q, ref_top());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pstack.md
Name: pstack

Overview:
- Predicate (active-lane mask) stack for the SIMT scheduler of the GPU.
- Holds one N_CORES-bit lane-enable mask per nesting level of divergent control flow.
- The top-of-stack is driven on q and gates which cores execute.
- The scheduler pushes a branch predicate, complements it for the else-path, and pops it at reconvergence.

Parameters:
- N_CORES, 4, number of lanes (mask width); the codebase takes this from the global `N_CORES constant.
- DEPTH, 8, number of pushable levels above the base entry.
- PTR_W, clog2(DEPTH+1), width of the level pointer (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- d  input  N_CORES  predicate mask to push.
- q  output  N_CORES  current top-of-stack mask (active lanes).
- push  input  1  push request.
- pop  input  1  pop request.
- comp  input  1  complement-top request (else-path).

Behaviour:
- Storage: a base entry (level 0) plus DEPTH pushable entries; a level pointer lvl ranges 0..DEPTH.
- Base entry is hardwired all-ones: all lanes are active when nothing is pushed.
- q = entry[lvl]. It is combinational from registered state, so the effect of an operation is visible on q after the rising edge where it is sampled.
- Reset (reset==0, asynchronous): lvl=0, all pushable entries cleared to 0, q=all-ones immediately. Reset dominates all requests; reset mid-operation discards the whole stack.
- Requests are level-sampled on every rising edge; each cycle a request is high performs one operation. Callers pulse for exactly one cycle per operation.
- Priority when several requests are high in the same cycle: pop > push > comp. Only one operation is performed per cycle.
- push:
  - If lvl<DEPTH: entry[lvl+1] <= d & entry[lvl], and lvl <= lvl+1.
  - Nested masks never enable a lane that the enclosing level disabled.
  - If lvl==DEPTH (full): ignored, no state change.
- comp:
  - If lvl>=1: entry[lvl] <= ~entry[lvl] & entry[lvl-1].
  - Applying comp twice restores the original top.
  - If lvl==0: ignored; the base entry is never modified.
- pop:
  - If lvl>=1: lvl <= lvl-1, exposing the previous mask. The popped entry's contents need not be cleared.
  - If lvl==0 (empty): ignored; q stays all-ones.
- No request high: state holds.
- X or undriven requests are not supported. Callers drive push, pop and comp to 0 when idle.
- Implementation note: register array with pointer; no combinational path from d to q.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> q=1111 immediately on assertion and after release; pop with nothing pushed -> q stays 1111.
- Push sequence, each a one-cycle pulse:
  - push d=1010 -> q=1010.
  - push d=0011 -> q=0010 (AND with 1010).
  - push d=0111 -> q=0010.
- Complement, continuing from the push sequence: comp -> q=0000 (~0010 & 0010); comp again -> q=0010 (restored).
- Pop chain, continuing: pop -> 0010, pop -> 1010, pop -> 1111, pop (empty) -> 1111.
- Full and priority:
  - Push DEPTH times with d=1111, then a further push of d=0000 -> ignored, q=1111.
  - From lvl=1 with top 1010, assert push=1 and pop=1 together -> pop wins, q=1111.
  - Assert comp at lvl=0 -> q=1111.
- Async reset mid-stack: at lvl=3, drive reset=0 between clock edges -> q=1111 without waiting for a clock edge; after release, a single pop -> q=1111.
